led_bank_driver: RTL

- Parametrised, registered LED bank driver; successor to the fixed 8-bit enable-gated LED register.
- Sits between the UART RX/TX data paths or status logic and the board LED pins.
- Adds configurable width, a pattern latch, blink mode and per-bit pulse stretching, so single-cycle events are visible to a human.

---
 rtl/led_bank_driver.sv | 116 +++++++++++
 1 files changed

// File: rtl/led_bank_driver.sv
// LED bank driver: live/hold/blink/stretch modes, pattern latch, optional PWM dimming (LED_PWM_EN).
// Latency 1 cycle from any input to LEDOut; no backpressure, every input is sampled each cycle.
module led_bank_driver #(
  parameter int WIDTH          = 8,
  parameter int BLINK_DIV      = 25000000,
  parameter int STRETCH_CYCLES = 2500000,
  parameter int PWM_BITS       = 4
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                En,
  input  logic [1:0]          Mode,
  input  logic                Load,
  input  logic [WIDTH-1:0]    DataIn,
  input  logic [PWM_BITS-1:0] Brightness,
  output logic [WIDTH-1:0]    LEDOut
);
  localparam int PW = $clog2(BLINK_DIV + 1);
  localparam int SW = $clog2(STRETCH_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_MAX    = PW'(BLINK_DIV - 1);
  localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH_CYCLES);

  localparam logic [1:0] MODE_LIVE    = 2'd0;
  localparam logic [1:0] MODE_HOLD    = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_STRETCH = 2'd3;

  logic [WIDTH-1:0] pattern;
  logic [PW-1:0]    presc;
  logic             phase;
  logic [SW-1:0]    stretch_cnt [WIDTH];
  logic [WIDTH-1:0] stretch_act;
  logic [WIDTH-1:0] pat_eff;
  logic [WIDTH-1:0] led_nxt;
  logic             pwm_on;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pattern <= '0;
    end else if (Load) begin
      pattern <= DataIn;
    end
  end

  // Prescaler and phase run in every mode and ignore En so blink timing never slips.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      presc <= '0;
      phase <= 1'b0;
    end else if (presc == PRESC_MAX) begin
      presc <= '0;
      phase <= ~phase;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < WIDTH; i++) stretch_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (DataIn[i]) begin
          stretch_cnt[i] <= STRETCH_LOAD;
        end else if (stretch_cnt[i] != '0) begin
          stretch_cnt[i] <= stretch_cnt[i] - SW'(1);
        end
      end
    end
  end

  always_comb begin
    stretch_act = '0;
    for (int i = 0; i < WIDTH; i++) stretch_act[i] = (stretch_cnt[i] != '0);
  end

`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // All-ones brightness is full on rather than (2^N-1)/2^N duty.
  assign pwm_on = (Brightness == '1) || (pwm_cnt < Brightness);
`else
  logic unused_brightness;
  assign unused_brightness = ^Brightness;
  assign pwm_on = 1'b1;
`endif

  always_comb begin
    pat_eff = Load ? DataIn : pattern;
    led_nxt = '0;
    case (Mode)
      MODE_LIVE:    led_nxt = DataIn;
      MODE_HOLD:    led_nxt = pat_eff;
      MODE_BLINK:   led_nxt = phase ? pat_eff : '0;
      MODE_STRETCH: led_nxt = DataIn | stretch_act;
      default:      led_nxt = '0;
    endcase
    if (!En || !pwm_on) led_nxt = '0;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      LEDOut <= '0;
    end else begin
      LEDOut <= led_nxt;
    end
  end
endmodule
